// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and encodings for the multi-channel PWM core
package pwm_pkg;
  localparam int CFG_INV = 0;
  localparam int CFG_DT_EN = 1;
  localparam int CFG_POL_A = 2;
  localparam int CFG_POL_B = 3;
  localparam int CFG_EN_A = 4;
  localparam int CFG_EN_B = 5;
  typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} mode_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DT_WIDTH = 8;
  localparam int DEF_RCR_WIDTH = 8;
endpackage

// File: rtl/pwm_mc_channel.sv
// pwm_mc_channel: window compare, registered reference, dead-time insertion and output stage
module pwm_mc_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DT_WIDTH = DEF_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    cnt,
  input  logic [WIDTH-1:0]    cmp_start,
  input  logic [WIDTH-1:0]    cmp_end,
  input  logic [DT_WIDTH-1:0] dtg,
  input  logic [7:0]          cfg,
  output logic                pwm_a,
  output logic                pwm_b
);
  logic ref_q, ref_n, dt_on, lvl_a, lvl_b;
  logic [DT_WIDTH-1:0] dt_cnt;
  logic unused_rsvd;
  assign unused_rsvd = ^cfg[7:6];
  always_comb begin
    ref_n = (cnt >= cmp_start && cnt < cmp_end) ^ cfg[CFG_INV];
    dt_on = cfg[CFG_DT_EN] && dtg != '0;
    lvl_a = dt_on ? ref_q && dt_cnt >= dtg : ref_q;
    lvl_b = dt_on ? !ref_q && dt_cnt >= dtg : !ref_q;
  end
  // dt_cnt saturates at all-ones so a later, larger dtg still sees the true run length
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ref_q <= 1'b0;
      dt_cnt <= '0;
      pwm_a <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      ref_q <= ref_n;
      dt_cnt <= (ref_n != ref_q) ? '0 : (dt_cnt == '1 ? dt_cnt : dt_cnt + DT_WIDTH'(1));
      pwm_a <= (cfg[CFG_EN_A] & lvl_a) ^ cfg[CFG_POL_A];
      pwm_b <= (cfg[CFG_EN_B] & lvl_b) ^ cfg[CFG_POL_B];
    end
endmodule

// File: rtl/pwm_core_mc.sv
// pwm_core_mc: shadowed prescaler, edge/center time base and repetition counter driving NUM_CH channels
module pwm_core_mc
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DT_WIDTH = DEF_DT_WIDTH,
  parameter int RCR_WIDTH = DEF_RCR_WIDTH
) (
  input  logic                         clk_psc_i,
  input  logic                         rst_i,
  input  logic                         cnt_en_i,
  input  logic                         center_i,
  input  logic                         ug_i,
  input  logic [WIDTH-1:0]             psc_i,
  input  logic [WIDTH-1:0]             arr_i,
  input  logic [RCR_WIDTH-1:0]         rcr_i,
  input  logic [NUM_CH*WIDTH-1:0]      cmp_start_i,
  input  logic [NUM_CH*WIDTH-1:0]      cmp_end_i,
  input  logic [NUM_CH*DT_WIDTH-1:0]   dtg_i,
  input  logic [NUM_CH*8-1:0]          cfg_i,
  output logic [WIDTH-1:0]             cnt_o,
  output logic                         dir_o,
  output logic                         update_o,
  output logic [NUM_CH-1:0]            pwm_a_o,
  output logic [NUM_CH-1:0]            pwm_b_o
);
  logic [WIDTH-1:0] psc_sh, arr_sh, psc_cnt, cnt_n;
  logic [RCR_WIDTH-1:0] rcr_sh, rep_cnt;
  mode_e center_sh;
  logic [NUM_CH*WIDTH-1:0] start_sh, end_sh;
  logic [NUM_CH*DT_WIDTH-1:0] dtg_sh;
  logic [NUM_CH*8-1:0] cfg_sh;
  logic tick, evt, dir_n, uev;
  // evt is the overflow/underflow the next tick would produce from the current count
  always_comb begin
    tick = cnt_en_i && psc_cnt >= psc_sh;
    if (arr_sh == '0) begin
      evt = 1'b1;
      cnt_n = '0;
      dir_n = 1'b0;
    end else if (center_sh == EDGE) begin
      evt = cnt_o >= arr_sh;
      cnt_n = evt ? '0 : cnt_o + WIDTH'(1);
      dir_n = 1'b0;
    end else if (!dir_o) begin
      evt = cnt_o >= arr_sh - WIDTH'(1);
      cnt_n = evt ? arr_sh : cnt_o + WIDTH'(1);
      dir_n = evt;
    end else begin
      evt = cnt_o <= WIDTH'(1);
      cnt_n = evt ? '0 : cnt_o - WIDTH'(1);
      dir_n = !evt;
    end
    uev = ug_i || (tick && evt && rep_cnt == '0);
  end
  always_ff @(posedge clk_psc_i or posedge rst_i)
    if (rst_i) begin
      psc_sh <= '0;
      arr_sh <= '0;
      rcr_sh <= '0;
      center_sh <= EDGE;
      start_sh <= '0;
      end_sh <= '0;
      dtg_sh <= '0;
      cfg_sh <= '0;
      psc_cnt <= '0;
      rep_cnt <= '0;
      cnt_o <= '0;
      dir_o <= 1'b0;
      update_o <= 1'b0;
    end else begin
      update_o <= uev;
      if (!cnt_en_i || uev) begin
        psc_sh <= psc_i;
        arr_sh <= arr_i;
        rcr_sh <= rcr_i;
        center_sh <= mode_e'(center_i);
        start_sh <= cmp_start_i;
        end_sh <= cmp_end_i;
        dtg_sh <= dtg_i;
        cfg_sh <= cfg_i;
      end
      if (ug_i) begin
        psc_cnt <= '0;
        cnt_o <= '0;
        dir_o <= 1'b0;
        rep_cnt <= rcr_i;
      end else if (cnt_en_i) begin
        psc_cnt <= tick ? '0 : psc_cnt + WIDTH'(1);
        if (tick) begin
          cnt_o <= cnt_n;
          dir_o <= dir_n;
          if (evt) rep_cnt <= rep_cnt == '0 ? rcr_sh : rep_cnt - RCR_WIDTH'(1);
        end
      end
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_mc_channel #(.WIDTH(WIDTH), .DT_WIDTH(DT_WIDTH)) u_ch (
      .clk(clk_psc_i),
      .rst(rst_i),
      .cnt(cnt_o),
      .cmp_start(start_sh[i*WIDTH +: WIDTH]),
      .cmp_end(end_sh[i*WIDTH +: WIDTH]),
      .dtg(dtg_sh[i*DT_WIDTH +: DT_WIDTH]),
      .cfg(cfg_sh[i*8 +: 8]),
      .pwm_a(pwm_a_o[i]),
      .pwm_b(pwm_b_o[i])
    );
  end
endmodule

// File: tb/tb_pwm_core_mc.sv
// tb_pwm_core_mc: phase-based reference model feeding a scoreboard, plus directed period/pulse checks
module tb_pwm_core_mc;
  localparam int W = 16;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int RW = 8;
  logic clk = 0, rst = 1, cnt_en = 0, center = 0, ug = 0;
  logic [W-1:0] psc = 0, arr = 0;
  logic [RW-1:0] rcr = 0;
  logic [N*W-1:0] cmp_start = 0, cmp_end = 0;
  logic [N*DW-1:0] dtg = 0;
  logic [N*8-1:0] cfg = 0;
  logic [W-1:0] cnt;
  logic dir, upd;
  logic [N-1:0] pwm_a, pwm_b;
  int n_checks = 0, n_fail = 0;
  typedef struct packed {logic [W-1:0] cnt; logic dir; logic upd; logic [N-1:0] a; logic [N-1:0] b;} obs_t;
  obs_t q[$];
  int s_psc, s_arr, s_rcr, s_center;
  int s_start[N], s_end[N], s_dtg[N], s_cfg[N];
  int m_psc, m_phase, m_rep, m_cnt;
  bit m_dir, m_upd;
  logic [N-1:0] m_a, m_b;
  logic [15:0] hist[N];

  pwm_core_mc #(.WIDTH(W), .NUM_CH(N), .DT_WIDTH(DW), .RCR_WIDTH(RW)) dut (
    .clk_psc_i(clk), .rst_i(rst), .cnt_en_i(cnt_en), .center_i(center), .ug_i(ug),
    .psc_i(psc), .arr_i(arr), .rcr_i(rcr), .cmp_start_i(cmp_start), .cmp_end_i(cmp_end),
    .dtg_i(dtg), .cfg_i(cfg), .cnt_o(cnt), .dir_o(dir), .update_o(upd),
    .pwm_a_o(pwm_a), .pwm_b_o(pwm_b));

  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic void load_shadows();
    s_psc = psc; s_arr = arr; s_rcr = rcr; s_center = center;
    for (int i = 0; i < N; i++) begin
      s_start[i] = cmp_start[i*W +: W];
      s_end[i] = cmp_end[i*W +: W];
      s_dtg[i] = dtg[i*DW +: DW];
      s_cfg[i] = cfg[i*8 +: 8];
    end
  endfunction

  function automatic void model_reset();
    s_psc = 0; s_arr = 0; s_rcr = 0; s_center = 0;
    m_psc = 0; m_phase = 0; m_rep = 0; m_cnt = 0; m_dir = 0; m_upd = 0; m_a = 0; m_b = 0;
    for (int i = 0; i < N; i++) begin
      s_start[i] = 0; s_end[i] = 0; s_dtg[i] = 0; s_cfg[i] = 0;
      hist[i] = 16'hFFFE;
    end
  endfunction

  // Time base is tracked as a position within the period; counter value and direction follow from it.
  // Dead time is judged from the run length of identical reference values in hist.
  function automatic void model_step();
    logic [N-1:0] na, nb;
    logic r;
    bit ones, zeros, uev;
    int p, np, d;
    for (int i = 0; i < N; i++) begin
      d = (s_cfg[i][1] && s_dtg[i] != 0) ? s_dtg[i] : 0;
      ones = 1; zeros = 1;
      for (int k = 0; k <= d; k++) begin
        if (hist[i][k] !== 1'b1) ones = 0;
        if (hist[i][k] !== 1'b0) zeros = 0;
      end
      na[i] = (s_cfg[i][4] & ones) ^ s_cfg[i][2];
      nb[i] = (s_cfg[i][5] & zeros) ^ s_cfg[i][3];
      r = (m_cnt >= s_start[i] && m_cnt < s_end[i]) ^ s_cfg[i][0];
      hist[i] = {hist[i][14:0], r};
    end
    uev = 0;
    if (ug) begin
      m_psc = 0; m_phase = 0; m_cnt = 0; m_dir = 0; m_rep = rcr; uev = 1;
    end else if (cnt_en) begin
      if (m_psc >= s_psc) begin
        m_psc = 0;
        p = s_arr == 0 ? 1 : (s_center != 0 ? 2 * s_arr : s_arr + 1);
        np = (m_phase + 1) % p;
        m_phase = np;
        m_cnt = (s_center != 0 && np > s_arr) ? 2 * s_arr - np : np;
        m_dir = s_center != 0 && s_arr != 0 && np >= s_arr;
        if (s_arr == 0 || np == 0 || (s_center != 0 && np == s_arr)) begin
          if (m_rep == 0) begin uev = 1; m_rep = s_rcr; end
          else m_rep--;
        end
      end else m_psc++;
    end
    m_upd = uev; m_a = na; m_b = nb;
    if (!cnt_en || uev) load_shadows();
    q.push_back(obs_t'({W'(m_cnt), m_dir, m_upd, m_a, m_b}));
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      model_reset();
      q.delete();
    end else model_step();

  always @(negedge clk) begin : mon
    obs_t got, e;
    got = {cnt, dir, upd, pwm_a, pwm_b};
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got cnt=%0d dir=%b upd=%b a=%b b=%b expected cnt=%0d dir=%b upd=%b a=%b b=%b",
                 $time, got.cnt, got.dir, got.upd, got.a, got.b, e.cnt, e.dir, e.upd, e.a, e.b);
      end
    end else if (rst) chk("reset_hold", int'(got), 0);
  end

  task automatic cyc(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic restart();
    cnt_en = 0; ug = 1;
    cyc(1);
    ug = 0; cnt_en = 1;
  endtask

  task automatic set_ch(int ch, int st, int en_, int dt, int cf);
    cmp_start[ch*W +: W] = W'(st);
    cmp_end[ch*W +: W] = W'(en_);
    dtg[ch*DW +: DW] = DW'(dt);
    cfg[ch*8 +: 8] = 8'(cf);
  endtask

  task automatic count_hi(int n, int ch, output int na, output int nb, output int nu);
    na = 0; nb = 0; nu = 0;
    repeat (n) begin
      cyc(1);
      na += int'(pwm_a[ch]); nb += int'(pwm_b[ch]); nu += int'(upd);
    end
  endtask

  task automatic wait_upd(string name, int lim, output int waited);
    waited = 0;
    do begin cyc(1); waited++; end while (!upd && waited < lim);
    chk({name, "_seen"}, int'(upd), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a, b, u, w;
    cyc(2);
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_pwm", int'({pwm_a, pwm_b, dir, upd}), 0);
    rst = 0;
    for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0);
    // basic edge PWM
    center = 0; psc = 0; arr = 9; rcr = 0;
    set_ch(0, 2, 5, 0, 'h30);
    restart(); cyc(25);
    count_hi(10, 0, a, b, u);
    chk("edge_a_high", a, 3); chk("edge_b_high", b, 7); chk("edge_upd", u, 1);
    // prescaler
    psc = 3;
    restart(); cyc(20);
    wait_upd("psc_first", 100, w);
    wait_upd("psc_period", 100, w);
    chk("psc_period", w, 40);
    count_hi(80, 0, a, b, u);
    chk("psc_upd_count", u, 2);
    // center mode and repetition
    psc = 0; center = 1; arr = 4; rcr = 0;
    restart(); cyc(10);
    count_hi(16, 0, a, b, u);
    chk("center_rcr0_upd", u, 4);
    rcr = 1;
    restart(); cyc(10);
    count_hi(16, 0, a, b, u);
    chk("center_rcr1_upd", u, 2);
    wait_upd("center_rcr1", 20, w);
    chk("center_rcr1_cnt", int'(cnt), 0); chk("center_rcr1_dir", int'(dir), 0);
    cyc(4);
    chk("center_top_cnt", int'(cnt), 4); chk("center_top_dir", int'(dir), 1);
    // dead time
    center = 0; arr = 9; rcr = 0;
    set_ch(0, 2, 4, 3, 'h32); set_ch(1, 2, 7, 3, 'h32);
    restart(); cyc(25);
    count_hi(10, 0, a, b, u);
    chk("dt_short_a", a, 0); chk("dt_short_b", b, 5);
    count_hi(10, 1, a, b, u);
    chk("dt_long_a", a, 2); chk("dt_long_b", b, 2);
    // shadow update and ug
    set_ch(0, 2, 5, 0, 'h30); set_ch(1, 0, 0, 0, 0);
    restart(); cyc(3);
    arr = 19;
    wait_upd("shadow_cur", 50, w);
    chk("shadow_cur_period", w, 7);
    wait_upd("shadow_next", 50, w);
    chk("shadow_next_period", w, 20);
    cyc(5);
    ug = 1; cyc(1); ug = 0;
    chk("ug_cnt", int'(cnt), 0); chk("ug_upd", int'(upd), 1);
    // asynchronous reset mid-run
    cyc(6);
    #2 rst = 1;
    #1;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_out", int'({pwm_a, pwm_b, dir, upd}), 0);
    cyc(2);
    rst = 0;
    cyc(1); chk("post_rst_cnt0", int'(cnt), 0);
    cyc(1); chk("post_rst_cnt1", int'(cnt), 1);
    cyc(1); chk("post_rst_cnt2", int'(cnt), 2);
    // randomized configurations, enable gaps and software updates
    for (int s = 0; s < 40; s++) begin
      cnt_en = 0;
      center = 1'($urandom % 2); psc = W'($urandom % 3); arr = W'($urandom % 13); rcr = RW'($urandom % 3);
      for (int c = 0; c < N; c++) set_ch(c, $urandom % 15, $urandom % 15, $urandom % 8, $urandom % 256);
      restart();
      for (int c = 0; c < 60; c++) begin
        cnt_en = ($urandom % 8) != 0;
        ug = ($urandom % 40) == 0;
        cyc(1);
      end
      ug = 0;
    end
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_core_mc.md
# pwm_core_mc

Parametrised successor to the two-channel PWM core. It runs one shared prescaler, one time-base counter and NUM_CH output-compare channels. The time base runs edge-aligned (up) or center-aligned (up/down). A repetition counter sets how often the update event fires, and all configuration goes through shadow registers, so changes take effect only at an update event. The block sits between the I2C register file and the pad outputs.

## Interface
- WIDTH, 16, counter/prescaler/compare width
- NUM_CH, 4, number of channels (1..16)
- DT_WIDTH, 8, dead-time counter width
- RCR_WIDTH, 8, repetition counter width

Clock, reset and ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_psc_i  in  1  block clock
- rst_i  in  1  asynchronous, active-high reset
- cnt_en_i  in  1  counter enable
- center_i  in  1  0 = edge-aligned up, 1 = center-aligned up/down
- ug_i  in  1  software update-generation pulse
- psc_i  in  WIDTH  prescaler divide-1
- arr_i  in  WIDTH  auto-reload (top) value
- rcr_i  in  RCR_WIDTH  repetition count
- cmp_start_i  in  NUM_CH*WIDTH  per-channel window start (channel k at [k*WIDTH +: WIDTH])
- cmp_end_i  in  NUM_CH*WIDTH  per-channel window end
- dtg_i  in  NUM_CH*DT_WIDTH  per-channel dead time, in clk_psc_i cycles
- cfg_i  in  NUM_CH*8  per-channel config byte:
  - [0] invert window
  - [1] dead-time enable
  - [2] main polarity
  - [3] comp polarity
  - [4] main enable
  - [5] comp enable
  - [7:6] reserved
- cnt_o  out  WIDTH  counter value
- dir_o  out  1  0 = up, 1 = down
- update_o  out  1  one-cycle pulse per update event (UEV)
- pwm_a_o  out  NUM_CH  main outputs
- pwm_b_o  out  NUM_CH  complementary outputs

## Operation
- **Shadow registers.** All psc/arr/rcr/cmp/dtg/cfg/center inputs have shadow registers.
  - While cnt_en_i=0 the shadows load every cycle.
  - While cnt_en_i=1 the shadows load only on UEV.
  - Reset value of every shadow is 0.
- **Prescaler.** psc_cnt counts 0..psc_sh. tick = (psc_cnt==psc_sh) && cnt_en_i. psc_sh=0 gives a tick every cycle.
- **Edge mode counter.** On tick: if cnt==arr_sh, then cnt←0 and an overflow event fires; otherwise cnt+1.
- **Center mode counter.**
  - Counting up: reaching arr_sh sets dir=1 and fires an overflow event.
  - Counting down: reaching 0 sets dir=0 and fires an underflow event.
  - The period is 2*arr_sh ticks.
- **arr_sh=0.** cnt stays 0 and every tick is one event.
- **Repetition counter.** On each event: if rep_cnt==0, then UEV fires and rep_cnt←rcr_sh (the pre-update value); otherwise rep_cnt-1. UEV therefore fires every rcr+1 events.
- **ug_i.** Next cycle it forces psc_cnt=0, cnt=0, dir=0, rep_cnt←rcr_i and a UEV. ug_i has priority over tick.
- **Channel reference.** ref = (cnt≥start && cnt<end) XOR cfg[0].
  - If start≥end, the window is empty and ref = cfg[0].
  - ref is registered.
- **Dead time disabled** (cfg[1]=0 or dtg=0): a=ref, b=~ref.
- **Dead time enabled.**
  - a rises dtg cycles after ref rises; b rises dtg cycles after ref falls. Each falls immediately when ref changes away from it.
  - A ref pulse shorter than dtg cycles is suppressed on that output.
  - The dead-time counter counts clk_psc_i cycles and keeps running when cnt_en_i=0.
- **Output stage.** pwm = (enable ? level : 0) XOR polarity, registered.
- **Counter disabled.** With cnt_en_i=0, cnt, dir, psc_cnt and rep_cnt hold their values. Outputs track the frozen cnt.

## Timing
- Reset (asynchronous, immediate):
  - cnt_o=0, dir_o=0, update_o=0, pwm_a_o=0, pwm_b_o=0.
  - All shadows and internal counters are 0.
- cnt_o changes in the cycle after the tick cycle.
- update_o is high for exactly one cycle, coincident with the cnt_o value after the event (0 in edge mode).
- pwm latency (dead time off): output reflects cnt_o 2 cycles later (ref register, then output register).
- New shadow values apply starting with the first tick after UEV.
- Simultaneous ug_i and tick: ug_i wins, and exactly one UEV fires.
- Reset deasserting mid-period: the counter restarts from 0 under the current inputs.

## Structure
- Shared package pwm_pkg holds:
  - cfg bit indices
  - mode encodings (EDGE=0, CENTER=1)
  - default parameter constants
- One sub-module, pwm_mc_channel, contains the comparator, ref register, dead-time generator and output stage. It is instantiated NUM_CH times in a generate loop.
- The top level contains the shadows, prescaler, counter and repetition logic.

## Test plan
1. Basic edge PWM:
   - Stimulus: edge mode, psc=0, arr=9, ch0 start=2 end=5, cfg=0x30 (both outputs enabled, no dead time).
   - Required: pwm_a_o[0] has a 10-cycle period and is high for 3 cycles (cnt 2..4 delayed by 2); pwm_b_o[0] is its complement.
2. Prescaler:
   - Stimulus: psc=3, arr=9.
   - Required: cnt_o steps every 4 cycles; period 40 cycles; update_o pulses every 40 cycles.
3. Center mode and repetition:
   - Stimulus: center mode, arr=4, psc=0.
   - Required: cnt sequence 0,1,2,3,4,3,2,1,0,…; dir_o=1 after 4.
   - rcr=0: update_o pulses at every 4 and every 0.
   - rcr=1: update_o pulses only at every 0 (alternate events).
4. Dead time:
   - Stimulus: dtg=3, cfg=0x32.
   - Required: a rises 3 cycles after ref rises, b falls immediately; window start=2 end=4 (2 cycles) leaves a low for the whole period.
5. Shadow update and ug_i:
   - Stimulus: running with arr=9; write arr=19 mid-period.
   - Required: the current period stays 10 cycles and the next period is 20.
   - Then pulse ug_i: cnt_o=0 and update_o=1 on the next cycle.
6. Reset mid-run:
   - Stimulus: assert rst_i asynchronously between clock edges.
   - Required: all outputs are 0 immediately; after release with cnt_en_i=1, cnt_o counts from 0.
